// File: rtl/gc_send.sv
// -----------------------------------------------------------------------------
// gc_send -- controller-side command frame transmitter.
//
// Serialises an 8- or 24-bit command onto an open-drain line. Every data bit
// lasts four quarter periods and starts low: a '0' stays low for three
// quarters, a '1' for one. A one-quarter low stop bit closes the frame.
//
// Ports
//   clk       in   system clock, rising-edge
//   rst       in   synchronous active-high reset
//   start     in   one-cycle frame request (ignored while busy or in done cycle)
//   cmd       in   [23:0] command, MSB first
//   long_cmd  in   1: send cmd[23:0], 0: send cmd[23:16]
//   data_oe   out  1 pulls the line low, 0 releases it
//   send      out  high for the whole frame, masks the receiver
//   busy      out  frame in progress
//   done      out  one-cycle pulse when the frame ends
// -----------------------------------------------------------------------------
module gc_send #(
  parameter int QUARTER = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cmd,
  input  logic        long_cmd,
  output logic        data_oe,
  output logic        send,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(3 * QUARTER + 1);

  // Phase lengths are loaded as "length - 1" and counted down to zero.
  localparam logic [CW-1:0] CNT_SHORT = CW'(QUARTER - 1);
  localparam logic [CW-1:0] CNT_LONG  = CW'(3 * QUARTER - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_LOW  = 2'd1,
    BIT_HIGH = 2'd2,
    STOP_LOW = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [4:0]    bits_q,  bits_d;    // bits still to send after the current one
  logic [23:0]   shift_q, shift_d;   // current bit is always shift_q[23]

  logic data_oe_q, data_oe_d;
  logic send_q,    send_d;
  logic busy_q,    busy_d;
  logic done_q,    done_d;

  logic expire;
  assign expire = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shift_d = shift_q;

    unique case (state_q)
      IDLE: begin
        // done_q marks the cycle right after a frame; a start there is dropped.
        if (start && !done_q) begin
          state_d = BIT_LOW;
          shift_d = cmd;
          bits_d  = long_cmd ? 5'd23 : 5'd7;
          cnt_d   = cmd[23] ? CNT_SHORT : CNT_LONG;
        end
      end

      BIT_LOW: begin
        if (expire) begin
          state_d = BIT_HIGH;
          cnt_d   = shift_q[23] ? CNT_LONG : CNT_SHORT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      BIT_HIGH: begin
        if (expire) begin
          if (bits_q == 5'd0) begin
            state_d = STOP_LOW;
            cnt_d   = CNT_SHORT;
          end else begin
            state_d = BIT_LOW;
            bits_d  = bits_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            // shift_q[22] is the bit about to become current.
            cnt_d   = shift_q[22] ? CNT_SHORT : CNT_LONG;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STOP_LOW: begin
        if (expire) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state and registered, so data_oe has
  // no combinational path from start or cmd and cannot glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_oe_d = (state_d == BIT_LOW) || (state_d == STOP_LOW);
    busy_d    = (state_d != IDLE);
    send_d    = busy_d;
    done_d    = (state_q == STOP_LOW) && (state_d == IDLE);
  end

  assign data_oe = data_oe_q;
  assign send    = send_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_gc_send.sv
// -----------------------------------------------------------------------------
// tb_gc_send -- self-checking bench for gc_send.
//
// The reference model turns (cmd, long_cmd) into the expected per-cycle
// data_oe waveform straight from the bit-timing rules, and each captured
// frame is compared against it.
// -----------------------------------------------------------------------------
module tb_gc_send;

  localparam int Q = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] cmd;
  logic        long_cmd;
  logic        data_oe;
  logic        send;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  gc_send #(.QUARTER(Q)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd),
    .long_cmd (long_cmd),
    .data_oe  (data_oe),
    .send     (send),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected data_oe for every busy cycle of one frame.
  function automatic void build_wave(input logic [23:0] c, input bit lg,
                                     output bit wave[$]);
    int n_bits;
    int low;
    wave.delete();
    n_bits = lg ? 24 : 8;
    for (int i = 0; i < n_bits; i++) begin
      low = c[23 - i] ? Q : 3 * Q;
      for (int k = 0; k < 4 * Q; k++) wave.push_back(k < low);
    end
    for (int k = 0; k < Q; k++) wave.push_back(1'b1);
  endfunction

  // Drives one accepted start and checks the whole frame. When noise is set,
  // inputs are scrambled after acceptance and stray starts are pulsed.
  task automatic run_frame(input string tag, input logic [23:0] c,
                           input bit lg, input bit noise);
    bit exp_wave[$];
    bit got_wave[$];
    int first_diff;
    int send_bad;
    int done_early;
    int cycles;

    build_wave(c, lg, exp_wave);
    start = 1'b1; cmd = c; long_cmd = lg;
    @(negedge clk);
    start = 1'b0;
    if (noise) begin
      cmd = 24'($urandom);
      long_cmd = ~lg;
    end
    check({tag, ":accept_busy"}, int'(busy), 1);
    check({tag, ":accept_oe"}, int'(data_oe), 1);

    send_bad = 0; done_early = 0; cycles = 0;
    while (busy === 1'b1 && cycles < 24 * 4 * Q + Q + 10) begin
      got_wave.push_back(data_oe);
      if (send !== 1'b1) send_bad++;
      if (done !== 1'b0) done_early++;
      start = noise && ($urandom_range(0, 9) == 0);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;

    first_diff = -1;
    for (int i = 0; i < exp_wave.size(); i++) begin
      if (first_diff < 0 && (i >= got_wave.size() || got_wave[i] != exp_wave[i]))
        first_diff = i;
    end
    check({tag, ":length"}, cycles, exp_wave.size());
    check({tag, ":wave_first_diff"}, first_diff, -1);
    check({tag, ":send_low_in_frame"}, send_bad, 0);
    check({tag, ":done_in_frame"}, done_early, 0);
    check({tag, ":done_pulse"}, int'(done), 1);
    check({tag, ":end_oe"}, int'(data_oe), 0);
    check({tag, ":end_send"}, int'(send), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 24 * 4 * Q + Q + 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":idle_reached"}, int'(busy), 0);
  endtask

  initial begin
    bit         exp_wave[$];
    bit         got_wave[$];
    logic [23:0] c;
    bit         lg;
    int         cycles;
    int         first_diff;
    int         dn;

    rst = 1'b1; start = 1'b0; cmd = '0; long_cmd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:oe",   int'(data_oe), 0);
    check("reset:send", int'(send), 0);
    check("reset:busy", int'(busy), 0);
    check("reset:done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames: poll, identify, alternating short frame.
    run_frame("poll",     24'h400300, 1'b1, 1'b0);
    @(negedge clk);
    check("post_poll:done_cleared", int'(done), 0);
    run_frame("identify", 24'h00BEEF, 1'b0, 1'b1);
    @(negedge clk);
    run_frame("a5",       24'hA50000, 1'b0, 1'b0);
    @(negedge clk);
    run_frame("all_ones", 24'hFFFFFF, 1'b1, 1'b1);
    @(negedge clk);

    // Randomised frames with stray starts and input scrambling.
    for (int i = 0; i < 10; i++) begin
      run_frame($sformatf("rand%0d", i), 24'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Start during the done cycle is dropped; one cycle later it is taken.
    run_frame("pre_done", 24'h123456, 1'b0, 1'b0);
    start = 1'b1; cmd = 24'h800000; long_cmd = 1'b0;  // sampled in done cycle
    @(negedge clk);
    check("start_in_done:ignored", int'(busy), 0);
    @(negedge clk);                                     // sampled one cycle later
    start = 1'b0;
    check("start_after_done:busy", int'(busy), 1);
    check("start_after_done:oe", int'(data_oe), 1);
    wait_idle("start_after_done");
    @(negedge clk);

    // Mid-frame reset: line released next cycle, no done, clean restart.
    start = 1'b1; cmd = 24'h400300; long_cmd = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort:oe",   int'(data_oe), 0);
    check("abort:send", int'(send), 0);
    check("abort:busy", int'(busy), 0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) dn++;
      @(negedge clk);
    end
    check("abort:no_done_no_busy", dn, 0);
    run_frame("after_abort", 24'h400300, 1'b1, 1'b0);
    @(negedge clk);

    // Reset wins over start sampled in the same cycle.
    rst = 1'b1; start = 1'b1; cmd = 24'hFFFFFF; long_cmd = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_vs_start:busy", int'(busy), 0);
    check("rst_vs_start:oe",   int'(data_oe), 0);
    @(negedge clk);
    check("rst_vs_start:still_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gc_send.md
GC_SEND -- requirements
Module: gc_send

Interface
REQ-001 Parameter QUARTER, default 100: clock cycles per quarter bit-time; 100 gives a 1 us quarter at 100 MHz clk; legal values are 2 or more.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to transmit a command frame.
REQ-005 cmd  input  24  command bits, sent MSB first.
REQ-006 long_cmd  input  1  selects frame length: 1 sends all 24 bits of cmd; 0 sends 8 bits, cmd[23:16].
REQ-007 data_oe  output  1  open-drain enable; 1 pulls the controller line low, 0 releases it.
REQ-008 send  output  1  transmit-in-progress flag; drives the receiver's send input.
REQ-009 busy  output  1  frame in progress; start is ignored while busy is high.
REQ-010 done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW; the block SHALL be busy in every state except IDLE.
REQ-012 Frame acceptance: in IDLE, start=1 at cycle N SHALL latch cmd and long_cmd; in cycle N+1, busy, send and data_oe SHALL all be 1.
REQ-013 cmd and long_cmd changes after acceptance SHALL not affect the frame in progress.
REQ-014 Bit length: every data bit SHALL last exactly 4*QUARTER cycles and SHALL begin with data_oe=1.
REQ-015 A '0' bit SHALL be 3*QUARTER cycles low, then QUARTER cycles released.
REQ-016 A '1' bit SHALL be QUARTER cycles low, then 3*QUARTER cycles released.
REQ-017 Bit order: bits SHALL be sent MSB first, i.e. cmd[23] down to cmd[0], or cmd[23] down to cmd[16] when long_cmd=0.
REQ-018 Stop bit: after the last data bit, the block SHALL drive data_oe=1 for QUARTER cycles (STOP_LOW).
REQ-019 Frame end: after STOP_LOW, data_oe, send and busy SHALL fall in the same cycle, done SHALL be 1 for that single cycle, and the state SHALL return to IDLE.
REQ-020 Frame length: from the first cycle with busy=1 to the last, a frame SHALL span exactly L*4*QUARTER + QUARTER cycles, where L is 8 or 24.
REQ-021 Counters: the quarter counter SHALL be at least clog2(3*QUARTER+1) bits; the bit counter SHALL be 5 bits and count down from L-1 to 0 with no wrap.
REQ-022 Start while busy SHALL be ignored and SHALL not be queued.
REQ-023 Start in the same cycle as done SHALL be ignored; start one cycle later SHALL be accepted.
REQ-024 send SHALL stay high for the whole frame, including STOP_LOW, so the receiver ignores every self-generated falling edge.
REQ-025 data_oe SHALL be registered and glitch-free, with no combinational path from start or cmd to data_oe.
REQ-026 The only transitions SHALL be: IDLE->BIT_LOW on start; BIT_LOW->BIT_HIGH on low-phase expiry; BIT_HIGH->BIT_LOW on expiry with bits remaining; BIT_HIGH->STOP_LOW on expiry of the last bit; STOP_LOW->IDLE on expiry.

Reset
REQ-027 rst=1 SHALL force state IDLE and data_oe, send, busy and done to 0 in the cycle after it is sampled, and SHALL clear the counters.
REQ-028 rst asserted mid-frame SHALL abort the frame: the line is released in the next cycle and no done pulse is issued.
REQ-029 rst SHALL take priority over start sampled in the same cycle.

Verification
REQ-030 Poll frame, QUARTER=100: start with cmd=0x400300, long_cmd=1 -> first bit is data_oe=1 for 300 cycles then 0 for 100; second bit is 1 for 100 then 0 for 300; 24 bits then a 100-cycle stop; busy lasts 9700 cycles; one done pulse.
REQ-031 Identify frame: cmd=0x00xxxx, long_cmd=0 -> 8 repetitions of 300 low/100 high, then 100 low; frame lasts 3300 cycles; cmd[15:0] is never sent.
REQ-032 Ignored start: start pulses at cycle 50 and in the done cycle of a frame -> no second frame; start one cycle after done -> new frame begins in the following cycle.
REQ-033 Mid-frame reset: rst at cycle 1000 of a poll frame -> data_oe, send and busy are 0 in the next cycle; no done; a subsequent start sends the full frame correctly.
REQ-034 Receiver loopback: data_oe drives a pull-up line shared with a behavioral controller that answers 64 bits after the stop bit; send is wired to the receiver -> the receiver returns the exact 64-bit response, button_data_ready pulses once, and no edges from the command frame are captured.
REQ-035 Small QUARTER: QUARTER=2 with cmd=0xA50000, long_cmd=0 -> bit pattern 1,0,1,0,0,1,0,1 with 2/6 and 6/2 cycle phases; frame lasts 66 cycles.
